// File: rtl/wimax_pkg.sv
// Shared types for the WiMAX interleaver datapath.
// bank_state_e: fill state of one ping-pong bank.
package wimax_pkg;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      FILLING  = 2'd1,
      FULL     = 2'd2,
      DRAINING = 2'd3
   } bank_state_e;

   localparam int BLOCK_BITS_QPSK = 192;

endpackage

// File: rtl/pp_bank_state.sv
// Fill-state tracker for one ping-pong bank.
// Ports: clk, resetN (async, active-low), clear (sync),
//   start_wr/done_wr, start_rd/done_rd event strobes; state out.
module pp_bank_state
   import wimax_pkg::*;
(
   input  logic        clk,
   input  logic        resetN,
   input  logic        clear,
   input  logic        start_wr,
   input  logic        done_wr,
   input  logic        start_rd,
   input  logic        done_rd,
   output bank_state_e state
);

   bank_state_e state_q;

   // A bank is never written and read in the same cycle, so the
   // priority order only matters for single-bit blocks.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= EMPTY;
      end else if (clear) begin
         state_q <= EMPTY;
      end else if (done_rd) begin
         state_q <= EMPTY;
      end else if (done_wr) begin
         state_q <= FULL;
      end else if (start_rd) begin
         state_q <= DRAINING;
      end else if (start_wr) begin
         state_q <= FILLING;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/pingpong_bank_ctrl.sv
// Ping-pong bank sequencer between the block interleaver and modulator.
// Ports: clk, resetN (async, active-low), flush (sync clear);
//   wr_valid/wr_index/wr_data/wr_ready from the interleaver;
//   mem_wr_*/mem_rd_*/mem_q to the two-bank bit memory;
//   out_data/out_valid/out_ready/out_last to the modulator; err.
// Option: define PPB_ERR_CHECK_EN for the range/protocol check on err.
module pingpong_bank_ctrl
   import wimax_pkg::*;
#(
   parameter int BLOCK_BITS = BLOCK_BITS_QPSK,
   parameter int ADDR_W     = 9
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              flush,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_index,
   input  logic              wr_data,
   output logic              wr_ready,
   output logic              mem_wr_en,
   output logic [ADDR_W:0]   mem_wr_addr,
   output logic              mem_wr_data,
   output logic              mem_rd_en,
   output logic [ADDR_W:0]   mem_rd_addr,
   input  logic              mem_q,
   output logic              out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              err
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BLOCK_BITS - 1);

   bank_state_e       st [2];
   logic              wb_q;
   logic              rb_q;
   logic [ADDR_W-1:0] wr_cnt_q;
   logic [ADDR_W-1:0] rd_cnt_q;
   logic              out_valid_q;
   logic              out_last_q;
   logic              out_valid_d;
   logic              out_last_d;

   logic              accept;
   logic              wr_done;
   logic              rd_issue;
   logic              rd_done;
   logic [1:0]        start_wr;
   logic [1:0]        done_wr;
   logic [1:0]        start_rd;
   logic [1:0]        done_rd;

   assign wr_ready = (st[wb_q] == EMPTY) || (st[wb_q] == FILLING);
   assign accept   = wr_valid && wr_ready && !flush;
   assign wr_done  = accept && (wr_cnt_q == LAST);

   assign rd_issue = ((st[rb_q] == FULL) || (st[rb_q] == DRAINING))
                     && (!out_valid_q || out_ready) && !flush;
   assign rd_done  = rd_issue && (rd_cnt_q == LAST);

   always_comb begin
      start_wr = 2'b00;
      done_wr  = 2'b00;
      start_rd = 2'b00;
      done_rd  = 2'b00;
      start_wr[wb_q] = accept && (st[wb_q] == EMPTY);
      done_wr[wb_q]  = wr_done;
      start_rd[rb_q] = rd_issue && (st[rb_q] == FULL);
      done_rd[rb_q]  = rd_done;
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      pp_bank_state u_bank (
         .clk      (clk),
         .resetN   (resetN),
         .clear    (flush),
         .start_wr (start_wr[b]),
         .done_wr  (done_wr[b]),
         .start_rd (start_rd[b]),
         .done_rd  (done_rd[b]),
         .state    (st[b])
      );
   end

   assign mem_wr_addr = {wb_q, wr_index};
   assign mem_wr_data = wr_data;
   assign mem_rd_en   = rd_issue;
   assign mem_rd_addr = {rb_q, rd_cnt_q};

   // A stalled bit stays presented; mem_q holds because no read issues.
   assign out_valid_d = rd_issue || (out_valid_q && !out_ready);
   assign out_last_d  = rd_issue ? rd_done
                                 : (out_valid_q && !out_ready && out_last_q);

   assign out_data  = mem_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

`ifdef PPB_ERR_CHECK_EN
   logic oor;
   logic err_q;

   // Out-of-range bits still advance the count so block framing holds.
   assign oor       = wr_index >= ADDR_W'(BLOCK_BITS);
   assign mem_wr_en = accept && !oor;
   assign err       = err_q;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         err_q <= 1'b0;
      end else if (flush) begin
         err_q <= 1'b0;
      end else if ((accept && oor)
                   || (out_valid_q && !out_ready && !out_valid_d)) begin
         err_q <= 1'b1;
      end
   end
`else
   assign mem_wr_en = accept;
   assign err       = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wb_q        <= 1'b0;
         rb_q        <= 1'b0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else if (flush) begin
         wb_q        <= 1'b0;
         rb_q        <= 1'b0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         if (accept) begin
            wr_cnt_q <= wr_done ? '0 : wr_cnt_q + 1'b1;
         end
         if (wr_done) begin
            wb_q <= !wb_q;
         end
         if (rd_issue) begin
            rd_cnt_q <= rd_done ? '0 : rd_cnt_q + 1'b1;
         end
         if (rd_done) begin
            rb_q <= !rb_q;
         end
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// Randomised bench for pingpong_bank_ctrl with a queue scoreboard.
// Build with PPB_ERR_CHECK_EN to exercise the error flag.
module tb_pingpong_bank_ctrl;

   localparam int BB = 192;
   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          resetN;
   logic          flush;
   logic          wr_valid;
   logic [AW-1:0] wr_index;
   logic          wr_data;
   logic          wr_ready;
   logic          mem_wr_en;
   logic [AW:0]   mem_wr_addr;
   logic          mem_wr_data;
   logic          mem_rd_en;
   logic [AW:0]   mem_rd_addr;
   logic          mem_q;
   logic          out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          err;

   always #5 clk = ~clk;

   pingpong_bank_ctrl #(.BLOCK_BITS(BB), .ADDR_W(AW)) dut (
      .clk         (clk),
      .resetN      (resetN),
      .flush       (flush),
      .wr_valid    (wr_valid),
      .wr_index    (wr_index),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_q       (mem_q),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .err         (err)
   );

   // Two-bank bit memory with registered read port.
   logic mem [0:2**(AW+1)-1];
   always @(posedge clk) begin
      if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
      if (mem_rd_en) mem_q <= mem[mem_rd_addr];
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: a block becomes a stream ordered by index.
   logic [1:0] expq [$];
   logic       blk [BB];
   int         wcnt, rcnt, nblk;
   logic       wpar, rpar;
   int         cycle = 0;
   int         nacc = 0;
   int         nout, nov, first_ov, last_ov, last_wr;

   task automatic clr_model();
      expq.delete();
      wcnt = 0;
      rcnt = 0;
      wpar = 1'b0;
      rpar = 1'b0;
   endtask

   task automatic clr_stats();
      nout = 0;
      nov = 0;
      first_ov = -1;
      last_ov = -1;
   endtask

   task automatic cyc();
      logic [1:0] e;
      logic       in_rng;
      @(negedge clk);
      cycle++;
      if (!wr_ready) chk("no_wr_when_full", 32'(mem_wr_en), 0);
      if (mem_rd_en) begin
         chk("rd_addr", 32'(mem_rd_addr), 32'({rpar, AW'(rcnt)}));
         rcnt++;
         if (rcnt == BB) begin
            rcnt = 0;
            rpar = ~rpar;
         end
      end
      if (out_valid) begin
         nov++;
         last_ov = cycle;
         if (first_ov < 0) first_ov = cycle;
      end
      if (out_valid && out_ready) begin
         nout++;
         if (expq.size() == 0) begin
            chk("spurious_out", 32'(out_valid), 0);
         end else begin
            e = expq.pop_front();
            chk("out_data", 32'(out_data), 32'(e[0]));
            chk("out_last", 32'(out_last), 32'(e[1]));
         end
      end
      if (wr_valid && wr_ready && !flush) begin
         in_rng = wr_index < BB;
`ifdef PPB_ERR_CHECK_EN
         chk("wr_en", 32'(mem_wr_en), 32'(in_rng));
`else
         chk("wr_en", 32'(mem_wr_en), 1);
`endif
         if (in_rng) begin
            chk("wr_addr", 32'(mem_wr_addr), 32'({wpar, wr_index}));
            blk[wr_index] = wr_data;
         end
         wcnt++;
         nacc++;
         last_wr = cycle;
         if (wcnt == BB) begin
            for (int k = 0; k < BB; k++) expq.push_back({k == BB - 1, blk[k]});
            wcnt = 0;
            wpar = ~wpar;
            nblk++;
         end
      end
      if (flush) clr_model();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_bit(input int idx, input logic d);
      logic acc;
      int   n = 0;
      wr_valid = 1'b1;
      wr_index = AW'(idx);
      wr_data  = d;
      do begin
         acc = wr_ready;
         cyc();
         n++;
      end while (!acc && n < 2000);
      if (!acc) chk("wr_stall", 32'(wr_ready), 1);
      wr_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      wr_valid  = 1'b0;
      out_ready = 1'b1;
      while ((expq.size() > 0 || out_valid) && n < 3000) begin
         cyc();
         n++;
      end
      repeat (4) cyc();
      chk("drain_left", 32'(expq.size()), 0);
   endtask

   int base;
   int held;
   int changes;
   logic ref_bit;

   initial begin
      resetN = 1'b0;
      flush = 1'b0;
      wr_valid = 1'b0;
      wr_index = '0;
      wr_data = 1'b0;
      out_ready = 1'b0;
      nblk = 0;
      clr_model();
      clr_stats();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wr_ready", 32'(wr_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_rd_en", 32'(mem_rd_en), 0);
      chk("rst_wr_en", 32'(mem_wr_en), 0);
      chk("rst_err", 32'(err), 0);
      resetN = 1'b1;
      @(posedge clk);
      #1;

      // Single block through the 802.16 first permutation.
      clr_stats();
      out_ready = 1'b1;
      for (int k = 0; k < BB; k++)
         wr_bit(12 * (k % 16) + k / 16, 1'($urandom));
      drain();
      chk("single_latency", 32'(first_ov - last_wr), 2);
      chk("single_count", 32'(nout), BB);

      // Four back-to-back blocks at full rate.
      clr_stats();
      base = nacc;
      wr_valid = 1'b1;
      for (int c = 0; c < 4 * BB; c++) begin
         wr_index = AW'((wcnt * 5 + 3) % BB);
         wr_data  = 1'($urandom);
         cyc();
      end
      wr_valid = 1'b0;
      chk("cont_accepts", 32'(nacc - base), 4 * BB);
      drain();
      chk("cont_gapless", 32'(last_ov - first_ov + 1 - nov), 0);
      chk("cont_count", 32'(nout), 4 * BB);

      // Output stalled for 500 cycles while the writer pushes.
      base = nacc;
      held = 0;
      changes = 0;
      out_ready = 1'b0;
      wr_valid = 1'b1;
      for (int c = 0; c < 500; c++) begin
         wr_index = AW'((wcnt * 7) % BB);
         wr_data  = 1'($urandom);
         cyc();
         if (out_valid) begin
            if (held == 0) ref_bit = out_data;
            else if (out_data !== ref_bit) changes++;
            held++;
         end
      end
      chk("bp_accepts", 32'(nacc - base), 2 * BB);
      chk("bp_wr_ready", 32'(wr_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_data_stable", 32'(changes), 0);
      drain();

      // Random valid/ready traffic over 20 blocks.
      base = nacc;
      for (int c = 0; c < 30000 && nacc - base < 20 * BB; c++) begin
         wr_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         wr_index  = AW'((wcnt * 5 + nblk * 7) % BB);
         wr_data   = 1'($urandom);
         cyc();
      end
      wr_valid = 1'b0;
      chk("rand_accepts", 32'(nacc - base), 20 * BB);
      drain();

      // Flush at bit 100 of the second block.
      out_ready = 1'b1;
      for (int k = 0; k < BB + 100; k++) wr_bit((k * 5) % BB, 1'($urandom));
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("flush_wr_ready", 32'(wr_ready), 1);
      chk("flush_out_valid", 32'(out_valid), 0);
      clr_stats();
      for (int k = 0; k < BB; k++) wr_bit((k * 11) % BB, 1'($urandom));
      drain();
      chk("flush_next_block", 32'(nout), BB);

      // Asynchronous reset in the middle of streaming.
      for (int k = 0; k < BB + 20; k++) wr_bit(k % BB, 1'($urandom));
      #2;
      resetN = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_rd_en", 32'(mem_rd_en), 0);
      chk("arst_wr_ready", 32'(wr_ready), 1);
      @(posedge clk);
      #1;
      resetN = 1'b1;
      clr_model();
      for (int k = 0; k < BB; k++) wr_bit((k * 13) % BB, 1'($urandom));
      drain();

`ifdef PPB_ERR_CHECK_EN
      chk("err_pre", 32'(err), 0);
      wr_bit(200, 1'b1);
      chk("err_set", 32'(err), 1);
      repeat (5) cyc();
      chk("err_sticky", 32'(err), 1);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("err_flush", 32'(err), 0);
`else
      wr_bit(5, 1'b1);
      chk("err_tied", 32'(err), 0);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
`endif
      chk("final_empty", 32'(out_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
